// File: rtl/draw_pair_writer.sv
// rtl/draw_pair_writer.sv - pair writer feeding both ports of a dual-port framebuffer RAM
module draw_pair_writer #(
   parameter int DATA_W       = 3,
   parameter int STALL_CYCLES = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [13:0]       addr_a,
   input  logic [13:0]       addr_b,
   input  logic [DATA_W-1:0] fg_colour,
   input  logic [DATA_W-1:0] bg_colour,
   output logic              we_a,
   output logic              we_b,
   output logic [13:0]       wr_addr_a,
   output logic [13:0]       wr_addr_b,
   output logic [DATA_W-1:0] wr_data_a,
   output logic [DATA_W-1:0] wr_data_b,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [13:0]       pair_count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [3:0]  STALL_LIM = 4'(STALL_CYCLES);
   localparam logic [13:0] COUNT_MAX = 14'h3FFF;

   state_t              r_state;
   logic                r_busy;
   logic                r_done;
   logic [DATA_W-1:0]   r_fg;
   logic [DATA_W-1:0]   r_bg;
   logic [3:0]          r_stall;
   logic                r_have_last;
   logic [13:0]         r_last_a;
   logic                r_we;
   logic [13:0]         r_wr_addr_a;
   logic [13:0]         r_wr_addr_b;
   logic [DATA_W-1:0]   r_wr_data_a;
   logic [DATA_W-1:0]   r_wr_data_b;
   logic                r_err;
   logic [13:0]         r_pair_count;

   logic                w_well_formed;
   logic                w_is_new;
   logic [3:0]          w_stall_next;
   logic [13:0]         w_addr_a_inc;

   // Pair qualification: even A address with B directly above it (wrapping at 14 bits)
   assign w_addr_a_inc  = addr_a + 14'd1;
   assign w_well_formed = ~addr_a[0] && (addr_b == w_addr_a_inc);
   assign w_is_new      = ~r_have_last || (addr_a != r_last_a);
   assign w_stall_next  = r_stall + 4'd1;

   // Run control, pair sampling and registered RAM write outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_fg         <= '0;
         r_bg         <= '0;
         r_stall      <= 4'd0;
         r_have_last  <= 1'b0;
         r_last_a     <= 14'd0;
         r_we         <= 1'b0;
         r_wr_addr_a  <= 14'd0;
         r_wr_addr_b  <= 14'd0;
         r_wr_data_a  <= '0;
         r_wr_data_b  <= '0;
         r_err        <= 1'b0;
         r_pair_count <= 14'd0;
      end else begin
         // strobes are single-cycle; address/data hold between writes
         r_we <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               // the pair present alongside start is deliberately not sampled
               if (start) begin
                  r_state      <= S_RUN;
                  r_busy       <= 1'b1;
                  r_done       <= 1'b0;
                  r_fg         <= fg_colour;
                  r_bg         <= bg_colour;
                  r_stall      <= 4'd0;
                  r_have_last  <= 1'b0;
                  r_err        <= 1'b0;
                  r_pair_count <= 14'd0;
               end
            end
            S_RUN: begin
               if (!w_well_formed) begin
                  r_err   <= 1'b1;
                  r_stall <= 4'd0;
               end else if (w_is_new) begin
                  r_we        <= 1'b1;
                  r_wr_addr_a <= addr_a;
                  r_wr_addr_b <= addr_b;
                  r_wr_data_a <= r_fg;
                  r_wr_data_b <= r_bg;
                  r_last_a    <= addr_a;
                  r_have_last <= 1'b1;
                  r_stall     <= 4'd0;
                  if (r_pair_count != COUNT_MAX) begin
                     r_pair_count <= r_pair_count + 14'd1;
                  end
               end else begin
                  // upstream counter is holding: count toward end of run
                  r_stall <= w_stall_next;
                  if (w_stall_next == STALL_LIM) begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign we_a       = r_we;
   assign we_b       = r_we;
   assign wr_addr_a  = r_wr_addr_a;
   assign wr_addr_b  = r_wr_addr_b;
   assign wr_data_a  = r_wr_data_a;
   assign wr_data_b  = r_wr_data_b;
   assign busy       = r_busy;
   assign done       = r_done;
   assign err        = r_err;
   assign pair_count = r_pair_count;

endmodule

// File: tb/tb_draw_pair_writer.sv
// tb/tb_draw_pair_writer.sv - randomized and directed bench for draw_pair_writer against a behavioural model
module tb_draw_pair_writer;
   localparam int DW = 3;
   localparam int SC = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [13:0]   addr_a;
   logic [13:0]   addr_b;
   logic [DW-1:0] fg_colour;
   logic [DW-1:0] bg_colour;
   logic          we_a;
   logic          we_b;
   logic [13:0]   wr_addr_a;
   logic [13:0]   wr_addr_b;
   logic [DW-1:0] wr_data_a;
   logic [DW-1:0] wr_data_b;
   logic          busy;
   logic          done;
   logic          err;
   logic [13:0]   pair_count;

   int n_pass   = 0;
   int n_total  = 0;
   int cyc      = 0;
   int n_writes = 0;

   // behavioural model: mode 0=idle 1=run 2=done
   int m_mode, m_fg, m_bg, m_cnt, m_stall, m_last, m_err, m_have;
   int e_we, e_wa, e_wb, e_da, e_db;

   always #5 clk = ~clk;

   draw_pair_writer #(.DATA_W(DW), .STALL_CYCLES(SC)) dut (
      .clk(clk), .reset(reset), .start(start),
      .addr_a(addr_a), .addr_b(addr_b),
      .fg_colour(fg_colour), .bg_colour(bg_colour),
      .we_a(we_a), .we_b(we_b),
      .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
      .wr_data_a(wr_data_a), .wr_data_b(wr_data_b),
      .busy(busy), .done(done), .err(err), .pair_count(pair_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      else n_pass++;
   endtask

   task automatic model_reset();
      m_mode = 0; m_cnt = 0; m_stall = 0; m_err = 0; m_have = 0; m_last = 0;
      e_we = 0; e_wa = 0; e_wb = 0; e_da = 0; e_db = 0;
   endtask

   // one clock edge of the specified behaviour, computed from the current inputs
   task automatic model_step();
      int a, b;
      a = int'(addr_a);
      b = int'(addr_b);
      e_we = 0;
      if (m_mode != 1 && start === 1'b1) begin
         m_mode = 1; m_fg = int'(fg_colour); m_bg = int'(bg_colour);
         m_cnt = 0; m_err = 0; m_stall = 0; m_have = 0;
      end else if (m_mode == 1) begin
         if ((a % 2) != 0 || b != (a + 1) % 16384) begin
            m_err = 1; m_stall = 0;
         end else if (m_have == 0 || a != m_last) begin
            e_we = 1; e_wa = a; e_wb = b; e_da = m_fg; e_db = m_bg;
            m_last = a; m_have = 1; m_stall = 0;
            if (m_cnt < 16383) m_cnt = m_cnt + 1;
         end else begin
            m_stall = m_stall + 1;
            if (m_stall == SC) m_mode = 2;
         end
      end
   endtask

   // compare process: every output against the model on every falling edge
   always @(negedge clk) begin
      chk("we_a", 32'(we_a), 32'(e_we));
      chk("we_b", 32'(we_b), 32'(e_we));
      chk("wr_addr_a", 32'(wr_addr_a), 32'(e_wa));
      chk("wr_addr_b", 32'(wr_addr_b), 32'(e_wb));
      chk("wr_data_a", 32'(wr_data_a), 32'(e_da));
      chk("wr_data_b", 32'(wr_data_b), 32'(e_db));
      chk("busy", 32'(busy), 32'(m_mode == 1));
      chk("done", 32'(done), 32'(m_mode == 2));
      chk("err", 32'(err), 32'(m_err));
      chk("pair_count", 32'(pair_count), 32'(m_cnt));
      if (we_a === 1'b1) n_writes++;
   end

   task automatic tick();
      @(posedge clk);
      if (reset === 1'b1) model_step();
      else model_reset();
      cyc++;
      #1;
   endtask

   task automatic put(input int a, input int b);
      addr_a = 14'(a);
      addr_b = 14'(b);
   endtask

   task automatic do_start(input int fg, input int bg);
      fg_colour = DW'(fg);
      bg_colour = DW'(bg);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // returns the cycle index at which done is first seen, or -1 on timeout
   task automatic wait_done(output int c);
      c = -1;
      for (int k = 0; k < 40; k++) begin
         if (done === 1'b1) begin
            c = cyc;
            break;
         end
         tick();
      end
      if (c < 0 && done === 1'b1) c = cyc;
   endtask

   initial begin
      int w0, c0, cd, sel, k;
      reset = 1'b0; start = 1'b0; addr_a = 14'd0; addr_b = 14'd0;
      fg_colour = '0; bg_colour = '0;
      model_reset();
      #2;
      // reset state, pinned with literals
      chk("rst_we", 32'(we_a | we_b), 32'd0);
      chk("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
      chk("rst_count", 32'(pair_count), 32'd0);
      chk("rst_addr", 32'(wr_addr_a | wr_addr_b), 32'd0);
      chk("rst_data", 32'(wr_data_a | wr_data_b), 32'd0);
      tick(); tick();
      reset = 1'b1;
      // no strobes for 20 cycles without start
      put(6656, 6657);
      w0 = n_writes;
      for (int i = 0; i < 20; i++) tick();
      chk("idle_no_writes", 32'(n_writes - w0), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);

      // nominal run: 129 pairs, then held
      put(6656, 6657);
      w0 = n_writes;
      do_start(5, 2);
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_no_sample", 32'(we_a), 32'd0);
      c0 = 0;
      for (int i = 0; i <= 128; i++) begin
         put(6656 + 2 * i, 6657 + 2 * i);
         c0 = cyc;
         tick();
         if (i == 0) begin
            chk("first_addr", 32'(wr_addr_a), 32'd6656);
            chk("first_data_a", 32'(wr_data_a), 32'd5);
            chk("first_data_b", 32'(wr_data_b), 32'd2);
         end
      end
      wait_done(cd);
      chk("nom_done_latency", 32'(cd - c0), 32'd5);
      chk("nom_writes", 32'(n_writes - w0), 32'd129);
      chk("nom_count", 32'(pair_count), 32'd129);
      chk("nom_last_addr_b", 32'(wr_addr_b), 32'd6913);
      chk("nom_err", 32'(err), 32'd0);

      // malformed pairs inside a run
      w0 = n_writes;
      do_start(3, 4);
      put(100, 101); tick();
      put(6657, 6658); tick();
      chk("mal1_err", 32'(err), 32'd1);
      chk("mal1_no_we", 32'(we_a), 32'd0);
      put(102, 103); tick();
      put(6656, 6660); tick();
      put(104, 105); tick();
      chk("mal_continue", 32'(wr_addr_a), 32'd104);
      // start in RUN is ignored
      start = 1'b1; fg_colour = 3'd7; tick(); start = 1'b0;
      chk("run_start_ignored_cnt", 32'(pair_count), 32'd3);
      chk("run_start_ignored_err", 32'(err), 32'd1);
      wait_done(cd);
      chk("mal_writes", 32'(n_writes - w0), 32'd3);
      chk("mal_err_sticky", 32'(err), 32'd1);

      // restart from DONE with new colours
      put(300, 301);
      do_start(1, 6);
      chk("restart_busy", 32'(busy), 32'd1);
      chk("restart_cnt", 32'(pair_count), 32'd0);
      chk("restart_err", 32'(err), 32'd0);
      tick();
      chk("restart_data_a", 32'(wr_data_a), 32'd1);
      chk("restart_data_b", 32'(wr_data_b), 32'd6);

      // interrupted stall: 3 repeats, new pair, 4 repeats
      put(200, 201); tick();
      for (int i = 0; i < 3; i++) tick();
      chk("stall3_not_done", 32'(done), 32'd0);
      put(202, 203); tick();
      chk("stall_new_written", 32'(wr_addr_a), 32'd202);
      for (int i = 0; i < 3; i++) tick();
      chk("stall_after3_not_done", 32'(done), 32'd0);
      tick();
      chk("stall_after4_done", 32'(done), 32'd1);
      chk("stall_done_no_we", 32'(we_a), 32'd0);

      // mid-run reset after 50 writes
      do_start(2, 5);
      for (int i = 0; i < 50; i++) begin
         put(6656 + 2 * i, 6657 + 2 * i);
         tick();
      end
      chk("pre_reset_we", 32'(we_a), 32'd1);
      reset = 1'b0;
      model_reset();
      #1;
      chk("async_we_drop", 32'(we_a | we_b), 32'd0);
      chk("async_count_clear", 32'(pair_count), 32'd0);
      tick(); tick();
      reset = 1'b1;
      tick(); tick();
      chk("post_reset_idle", 32'(busy), 32'd0);
      put(0, 1);
      do_start(4, 4);
      put(6656, 6657); tick();
      chk("post_reset_first", 32'(wr_addr_a), 32'd6656);
      chk("post_reset_count", 32'(pair_count), 32'd1);

      // pair_count saturation across address wrap
      for (int i = 1; i < 16400; i++) begin
         put((2 * i) % 16384, (2 * i) % 16384 + 1);
         tick();
      end
      chk("sat_count", 32'(pair_count), 32'd16383);

      // randomized phase
      for (int i = 0; i < 4000; i++) begin
         start = ($urandom_range(0, 99) < 4);
         fg_colour = DW'($urandom);
         bg_colour = DW'($urandom);
         sel = $urandom_range(0, 9);
         k = $urandom_range(0, 40);
         if (sel < 5) put(2 * k, 2 * k + 1);
         else if (sel < 7) begin
            if ($urandom_range(0, 1) == 1) put(2 * k + 1, 2 * k + 2);
            else put(2 * k, 2 * k + 3);
         end
         if (reset === 1'b1 && $urandom_range(0, 599) == 0) begin
            #2;
            reset = 1'b0;
            model_reset();
         end else if (reset === 1'b0 && $urandom_range(0, 3) == 0) begin
            reset = 1'b1;
         end
         tick();
      end
      reset = 1'b1;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
